// File: rtl/ascii_pkg.sv
// Shared ASCII constants, parser state encoding and sizing helper for
// RX command parsers.
package ascii_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    // Bits needed to hold the largest n-digit decimal number (10^n - 1).
    function automatic int unsigned acc_width(input int unsigned max_digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < max_digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/ascii_dist_parser_if.sv
// Byte-stream and result bundle between an RX FIFO producer and the
// ASCII distance parser.
interface ascii_dist_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [11:0] value;
    logic        value_valid;
    logic        err;
    logic        busy;

    modport master (
        output rx_data, rx_valid,
        input  rx_pop, value, value_valid, err, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_pop, value, value_valid, err, busy
    );
endinterface

// File: rtl/ascii_char_class.sv
// Classifies an ASCII byte as decimal digit or line terminator; inverse of
// the number-to-ASCII table.
module ascii_char_class
    import ascii_pkg::*;
#(
    parameter logic [7:0] TERM_CR = ASC_CR,
    parameter logic [7:0] TERM_LF = ASC_LF
) (
    input  logic [7:0] i_data,
    output logic       o_is_digit,
    output logic       o_is_term,
    output logic [3:0] o_digit
);

    logic [7:0] w_off;

    assign w_off      = i_data - ASC_0;
    assign o_is_digit = (i_data >= ASC_0) && (i_data <= ASC_9);
    assign o_is_term  = (i_data == TERM_CR) || (i_data == TERM_LF);
    assign o_digit    = 4'(w_off);

endmodule

// File: rtl/ascii_dist_parser.sv
// Assembles decimal ASCII lines from the RX FIFO into a DATA_W-bit value;
// malformed or out-of-range lines are dropped and flagged.
module ascii_dist_parser
    import ascii_pkg::*;
#(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned MAX_DIGITS = 4,
    parameter logic [7:0]  TERM_CR    = 8'h0D,
    parameter logic [7:0]  TERM_LF    = 8'h0A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_pop,
    output logic [DATA_W-1:0] o_value,
    output logic              o_value_valid,
    output logic              o_err,
    output logic              o_busy
);

    localparam int unsigned ACC_W = acc_width(MAX_DIGITS);
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'((1 << DATA_W) - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    state_t             r_state, w_next;
    logic [ACC_W-1:0]   r_acc, w_acc;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [DATA_W-1:0]  r_value;
    logic               r_value_valid, r_err, r_busy;
    logic               w_pop, w_load, w_err;
    logic               w_is_digit, w_is_term;
    logic [3:0]         w_digit;
    logic [ACC_W-1:0]   w_acc_x10;

    ascii_char_class #(
        .TERM_CR (TERM_CR),
        .TERM_LF (TERM_LF)
    ) u_class (
        .i_data     (i_rx_data),
        .o_is_digit (w_is_digit),
        .o_is_term  (w_is_term),
        .o_digit    (w_digit)
    );

    // Pop is held low through reset so the FIFO is never drained while idle.
    assign w_pop     = i_rx_valid && (r_state != EMIT) && rst_n;
    assign w_acc_x10 = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_acc         <= w_acc;
            r_cnt         <= w_cnt;
            r_value_valid <= w_load;
            r_err         <= w_err;
            r_busy        <= (w_next == ACCUM) || (w_next == SKIP);
            if (w_load) begin
                r_value <= r_acc[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_acc  = r_acc;
        w_cnt  = r_cnt;
        w_load = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    if (w_is_digit) begin
                        w_acc  = ACC_W'(w_digit);
                        w_cnt  = CNT_W'(1);
                        w_next = ACCUM;
                    end else if (!w_is_term) begin
                        w_next = SKIP;
                    end
                end
            end
            ACCUM: begin
                if (w_pop) begin
                    if (w_is_digit && (r_cnt < MAX_CNT)) begin
                        w_acc = w_acc_x10;
                        w_cnt = r_cnt + CNT_W'(1);
                    end else if (w_is_term) begin
                        w_acc = '0;
                        w_cnt = '0;
                        if (r_acc <= MAX_VAL) begin
                            w_load = 1'b1;
                            w_next = EMIT;
                        end else begin
                            w_err  = 1'b1;
                            w_next = IDLE;
                        end
                    end else begin
                        // Too many digits or a stray character: drop rest of line.
                        w_acc  = '0;
                        w_cnt  = '0;
                        w_next = SKIP;
                    end
                end
            end
            EMIT: begin
                w_acc  = '0;
                w_cnt  = '0;
                w_next = IDLE;
            end
            SKIP: begin
                if (w_pop && w_is_term) begin
                    w_err  = 1'b1;
                    w_acc  = '0;
                    w_cnt  = '0;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_rx_pop      = w_pop;
    assign o_value       = r_value;
    assign o_value_valid = r_value_valid;
    assign o_err         = r_err;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_ascii_dist_parser.sv
// Directed self-checking bench for ascii_dist_parser with a value scoreboard.
module tb_ascii_dist_parser;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   valid_cnt;
    int   err_cnt;
    int   pop_cnt;
    int   p0;
    int   exp_q[$];

    ascii_dist_parser_if bus ();

    ascii_dist_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_data     (bus.rx_data),
        .i_rx_valid    (bus.rx_valid),
        .o_rx_pop      (bus.rx_pop),
        .o_value       (bus.value),
        .o_value_valid (bus.value_valid),
        .o_err         (bus.err),
        .o_busy        (bus.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: pops, error pulses, and value pulses against the scoreboard.
    always @(negedge clk) begin
        #3;
        if (bus.rx_pop) pop_cnt++;
        if (!bus.rx_valid) chk("pop_without_valid", 32'(bus.rx_pop), 0);
        if (bus.err) err_cnt++;
        if (bus.value_valid) begin
            valid_cnt++;
            chk("err_with_valid", 32'(bus.err), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(bus.value), 32'hFFFF_FFFF);
            end else begin
                chk("value_on_valid", 32'(bus.value), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the last byte is consumed.
    task automatic send(input string s, input bit gap);
        int n;
        for (int i = 0; i < s.len(); i++) begin
            if (gap) begin
                bus.rx_valid = 1'b0;
                #1;
                chk("pop_in_gap", 32'(bus.rx_pop), 0);
                @(negedge clk);
            end
            bus.rx_data  = s[i];
            bus.rx_valid = 1'b1;
            #1;
            n = 0;
            while (!bus.rx_pop && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (!bus.rx_pop) chk("pop_timeout", 0, 1);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0; valid_cnt = 0; err_cnt = 0; pop_cnt = 0;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h35;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pop", 32'(bus.rx_pop), 0);
        chk("rst_value", 32'(bus.value), 0);
        chk("rst_valid", 32'(bus.value_valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "123\r": one pulse, four pops
        p0 = pop_cnt;
        exp_q.push_back(123);
        send("123\015", 1'b0);
        settle();
        chk("t1_valid_cnt", 32'(valid_cnt), 1);
        chk("t1_err_cnt", 32'(err_cnt), 0);
        chk("t1_pops", 32'(pop_cnt - p0), 4);
        chk("t1_value", 32'(bus.value), 123);

        // Max value with CR LF pair, then a short LF-terminated line
        exp_q.push_back(4095);
        exp_q.push_back(7);
        send("4095\015\012", 1'b0);
        send("7\012", 1'b0);
        settle();
        chk("t2_valid_cnt", 32'(valid_cnt), 3);
        chk("t2_err_cnt", 32'(err_cnt), 0);
        chk("t2_value", 32'(bus.value), 7);

        // Out of range, then too many digits: value must hold
        send("4096\015", 1'b0);
        settle();
        chk("t3a_err_cnt", 32'(err_cnt), 1);
        chk("t3a_value", 32'(bus.value), 7);
        send("12345\015", 1'b0);
        settle();
        chk("t3b_err_cnt", 32'(err_cnt), 2);
        chk("t3b_valid_cnt", 32'(valid_cnt), 3);
        chk("t3b_value", 32'(bus.value), 7);

        // Invalid char line, busy tracking, then a good line
        send("1", 1'b0);
        chk("t4_busy_digit", 32'(bus.busy), 1);
        send("a2", 1'b0);
        chk("t4_busy_skip", 32'(bus.busy), 1);
        send("\015", 1'b0);
        chk("t4_busy_done", 32'(bus.busy), 0);
        exp_q.push_back(55);
        send("55\015", 1'b0);
        settle();
        chk("t4_err_cnt", 32'(err_cnt), 3);
        chk("t4_valid_cnt", 32'(valid_cnt), 4);
        chk("t4_value", 32'(bus.value), 55);

        // Leading zeros with a stalling FIFO
        exp_q.push_back(42);
        send("0042\015", 1'b1);
        settle();
        chk("t5_valid_cnt", 32'(valid_cnt), 5);
        chk("t5_err_cnt", 32'(err_cnt), 3);
        chk("t5_value", 32'(bus.value), 42);

        // Reset in the middle of a line
        send("98", 1'b0);
        chk("t6_busy_pre", 32'(bus.busy), 1);
        rst_n        = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h33;
        #1;
        chk("t6_rst_pop", 32'(bus.rx_pop), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_value", 32'(bus.value), 0);
        chk("t6_rst_valid", 32'(bus.value_valid), 0);
        chk("t6_rst_err", 32'(bus.err), 0);
        repeat (2) @(negedge clk);
        bus.rx_valid = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        exp_q.push_back(6);
        send("6\015", 1'b0);
        settle();
        chk("t6_value", 32'(bus.value), 6);
        chk("t6_valid_cnt", 32'(valid_cnt), 6);
        chk("t6_err_cnt", 32'(err_cnt), 3);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascii_dist_parser.md
# ascii_dist_parser

Receive-side counterpart of the distance display/ASCII path: consumes the ASCII byte stream from the UART RX FIFO, and assembles decimal digit characters into a 12-bit binary value. It emits that value with a one-cycle valid strobe on a line terminator. Downstream logic uses it as a host-supplied distance threshold or test value, in the same 0..4095 range the FND controller displays. Malformed or out-of-range lines are discarded and flagged.

## Interface
- DATA_W, 12, width of output value; legal range 0..2^DATA_W-1
- MAX_DIGITS, 4, maximum decimal digits accepted per line
- TERM_CR, 8'h0D, line terminator 1
- TERM_LF, 8'h0A, line terminator 2
- clk  input  1  system clock; single clock domain
- rst_n  input  1  reset, asynchronous, active-low
- i_rx_data  input  8  RX FIFO head byte; show-ahead, valid whenever i_rx_valid=1
- i_rx_valid  input  1  RX FIFO not empty
- o_rx_pop  output  1  pop strobe; byte on i_rx_data is consumed at the clk edge where o_rx_pop=1
- o_value  output  DATA_W  last accepted value; held until next accepted line
- o_value_valid  output  1  one-cycle pulse: o_value updated this cycle
- o_err  output  1  one-cycle pulse: a line was rejected
- o_busy  output  1  1 while a line is partially received (states ACCUM, SKIP)

## Operation
- Byte classes: digit is '0'..'9' (8'h30..8'h39), with value = byte-8'h30. Terminator is TERM_CR or TERM_LF. Any other byte is invalid.
- o_rx_pop = i_rx_valid & (state != EMIT). The block pops and processes one byte per cycle.
- The accumulator is 14 bits, enough for 9999. The digit count runs 0..MAX_DIGITS.
- FSM states: IDLE, ACCUM, EMIT, SKIP.
- IDLE:
  - digit: acc <= d, cnt <= 1, go to ACCUM.
  - terminator: ignored, stay in IDLE. This absorbs CR LF pairs and empty lines.
  - invalid byte: go to SKIP.
- ACCUM:
  - digit with cnt < MAX_DIGITS: acc <= acc*10 + d, cnt++.
  - digit with cnt == MAX_DIGITS: overflow, go to SKIP.
  - invalid byte: go to SKIP.
  - terminator with acc <= 2^DATA_W-1: latch o_value <= acc[DATA_W-1:0], go to EMIT.
  - terminator with acc > 2^DATA_W-1: pulse o_err, clear acc/cnt, go to IDLE.
- EMIT: o_value_valid=1 for exactly this cycle. No pop. Clear acc/cnt, then go to IDLE unconditionally.
- SKIP: discard all non-terminator bytes. On a terminator, pulse o_err and go to IDLE.
- Leading zeros count toward MAX_DIGITS ("0042" is accepted, "00042" is rejected).
- o_value is never modified by a rejected line.

## Timing
- Reset (async assert, sync release) sets: state=IDLE, acc=0, cnt=0, o_value=0, o_value_valid=0, o_err=0, o_busy=0. o_rx_pop is forced low during reset.
- Latency: terminator popped at edge N. At edge N, o_value is latched and state becomes EMIT. o_value_valid is high during cycle N..N+1. The next pop can occur at edge N+2.
- o_err is registered: it goes high for the one cycle following the edge that consumed the rejecting terminator. It is never asserted together with o_value_valid.
- Back-to-back lines have no gap requirement on the input side. The only bubble is the single EMIT cycle.
- Reset asserted mid-line drops the partial line with no o_err. The first byte after release is treated as the start of a new line.
- i_rx_valid=0 simply stalls the FSM in its current state. There is no timeout.

## Structure
- Shared package ascii_pkg:
  - ASCII constants: ASC_0, ASC_9, ASC_CR, ASC_LF.
  - state enum: IDLE, ACCUM, EMIT, SKIP.
  - function for the max-digits accumulator width.
- One combinational sub-module ascii_char_class: maps i_rx_data to is_digit, is_term, digit[3:0]. It is the inverse of the number-to-ASCII table and is reusable by other RX command parsers.
- The top contains the FSM, accumulator (mult-by-10 as (acc<<3)+(acc<<1)), digit counter, and output registers.

## Test plan
- Send "123\r", FIFO always valid -> exactly one o_value_valid pulse with o_value=123, o_err never high, 4 pops total.
- Send "4095\r\n" then "7\n" -> pulses with o_value=4095 then 7; the LF after CR causes no pulse or err.
- Send "4096\r" -> one o_err pulse, no o_value_valid, o_value stays at its prior value. Then send "12345\r" -> one o_err pulse, o_value unchanged.
- Send "1a2\r" then "55\r" -> one o_err pulse for the first line, then o_value=55 with a valid pulse; o_busy is high from '1' until the terminator.
- Send "0042\r" with i_rx_valid toggling every other cycle -> o_value=42, exactly one valid pulse; o_rx_pop never asserted while i_rx_valid=0.
- Send "98", assert rst_n=0 for 2 cycles, release, send "6\r" -> o_value=6, no o_err; outputs read reset values during reset.
